pss8: RTL and testbench

- Parallel-to-serial transmitter; sits directly upstream of the serial-to-parallel receiver stage.
- Accepts WIDTH-bit words on a write strobe and shifts them out one bit per clock, LSB first. Bit order matches the receiver filling its word from index 0.
- A one-word holding register allows back-to-back words with no idle gap between frames.
- Emits a frame-sync marker on bit 0 of every word so the receiver can align its bit counter.

---
 rtl/pss8_pkg.sv | 17 +
 rtl/pss8.sv | 121 ++++++++++++
 tb/tb_pss8.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/pss8_pkg.sv
// pss8 shared types and sizing helpers.
// Also used by the serial-to-parallel receiver stage.
package pss8_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W = $clog2(WIDTH_DEF);

  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/pss8.sv
// Parallel-to-serial transmitter with one-word hold buffer.
// Frame-sync marks the first transmitted bit of every word.
module pss8
  import pss8_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] datai,
  input  logic             wr,
  output logic             datao,
  output logic             sync,
  output logic             busy,
  output logic             ready,
  output logic             ovf
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  function automatic logic [CW-1:0] bidx(
    input logic [CW-1:0] i
  );
    return MSB_FIRST ? LAST - i : i;
  endfunction

  state_t           st_q, st_n;
  logic [CW-1:0]    cnt_q, cnt_n, nxt;
  logic [WIDTH-1:0] shift_q, shift_n;
  logic [WIDTH-1:0] hold_q;
  logic             hold_v;
  logic             dout_q, dout_n;
  logic             sync_q, sync_n;
  logic             ovf_q;
  logic             ld;

  always_comb begin
    st_n    = st_q;
    cnt_n   = cnt_q;
    shift_n = shift_q;
    dout_n  = dout_q;
    sync_n  = sync_q;
    nxt     = cnt_q + CW'(1);
    ld      = 1'b0;
    unique case (1'b1)
      (st_q == IDLE): begin
        dout_n = 1'b0;
        sync_n = 1'b0;
        ld     = hold_v && start;
      end
      (st_q == SHIFT): begin
        if (start) begin
          if (cnt_q != LAST) begin
            cnt_n  = nxt;
            dout_n = shift_q[bidx(nxt)];
            sync_n = 1'b0;
          end else if (hold_v) begin
            ld = 1'b1;
          end else begin
            st_n   = IDLE;
            dout_n = 1'b0;
            sync_n = 1'b0;
          end
        end
      end
      default: ;
    endcase
    // Load path shared by idle start and gapless last-bit handover
    if (ld) begin
      shift_n = hold_q;
      cnt_n   = '0;
      dout_n  = hold_q[bidx('0)];
      sync_n  = 1'b1;
      st_n    = SHIFT;
    end
  end

  // Hold counts as empty when it drains on this same edge
  assign ready = !hold_v || ld;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      st_q    <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      dout_q  <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      st_q    <= st_n;
      cnt_q   <= cnt_n;
      shift_q <= shift_n;
      dout_q  <= dout_n;
      sync_q  <= sync_n;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      hold_q <= '0;
      hold_v <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (wr && ready) begin
        hold_q <= datai;
        hold_v <= 1'b1;
      end else if (ld) begin
        hold_v <= 1'b0;
      end
      if (wr && !ready) ovf_q <= 1'b1;
    end
  end

  assign datao = dout_q;
  assign sync  = sync_q;
  assign busy  = (st_q == SHIFT);
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_pss8.sv
// Bench for pss8: word-queue model, per-cycle compare,
// directed vectors and a small receiver for loopback.
module tb_pss8;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         clr   = 1'b1;
  logic         start = 1'b0;
  logic         wr    = 1'b0;
  logic [W-1:0] datai = '0;
  logic         datao, sync, busy, ready, ovf;

  int nvec = 0;
  int nerr = 0;

  pss8 #(.WIDTH(W), .MSB_FIRST(1'b0)) dut (
    .clk(clk), .clr(clr), .start(start),
    .datai(datai), .wr(wr), .datao(datao),
    .sync(sync), .busy(busy), .ready(ready),
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: position in current word (-1 idle) and a queue of held words
  int           pos  = -1;
  logic [W-1:0] cur  = '0;
  logic [W-1:0] hq[$];
  bit           movf = 1'b0;

  function automatic bit m_ready();
    return hq.size() == 0 ||
           (start && (pos < 0 || pos == W - 1));
  endfunction

  always @(posedge clk or posedge clr) begin
    bit rdy;
    if (clr) begin
      pos = -1;
      hq.delete();
      movf = 1'b0;
    end else begin
      rdy = m_ready();
      if (start) begin
        if (pos >= 0 && pos < W - 1) pos++;
        else if (hq.size() > 0) begin
          cur = hq.pop_front();
          pos = 0;
        end else pos = -1;
      end
      if (wr) begin
        if (rdy) hq.push_back(datai);
        else movf = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (!clr) begin
      chk("datao", datao, (pos < 0) ? 1'b0 : cur[pos]);
      chk("sync", sync, pos == 0);
      chk("busy", busy, pos >= 0);
      chk("ready", ready, m_ready());
      chk("ovf", ovf, movf);
    end
  end

  // Receiver: fills from index 0, aligned by sync
  int           rcnt = 0;
  logic [W-1:0] rw   = '0;
  logic [W-1:0] rxq[$];

  always @(negedge clk) begin
    if (clr) rcnt = 0;
    else begin
      if (sync) begin
        rw    = '0;
        rw[0] = datao;
        rcnt  = 1;
      end else if (rcnt > 0) begin
        rw[rcnt] = datao;
        rcnt++;
      end
      if (rcnt == W) begin
        rxq.push_back(rw);
        rcnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic bits(input logic [31:0] v,
                      input int from, input int to,
                      input string nm);
    for (int i = from; i <= to; i++) begin
      tick();
      chk({nm, "_bit"}, datao, v[i]);
      chk({nm, "_sync"}, sync, (i % W) == 0);
      chk({nm, "_busy"}, busy, 1'b1);
    end
  endtask

  logic [W-1:0] ew[3];
  int n;

  initial begin
    ew = '{8'h00, 8'hFF, 8'h5A};
    #12 clr = 1'b0;
    chk("rst_datao", datao, 0);
    chk("rst_sync", sync, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", ready, 1);
    chk("rst_ovf", ovf, 0);

    // single word
    start = 1'b1;
    datai = 8'hA5; wr = 1'b1;
    tick();
    wr = 1'b0;
    bits(32'hA5, 0, 7, "single");
    tick();
    chk("single_end_busy", busy, 0);
    chk("single_end_datao", datao, 0);

    // back-to-back
    datai = 8'h3C; wr = 1'b1;
    tick();
    datai = 8'hC3;
    tick();
    wr = 1'b0;
    chk("b2b_bit0", datao, 0);
    chk("b2b_sync0", sync, 1);
    bits(32'hC33C, 1, 15, "b2b");
    chk("b2b_ovf", ovf, 0);
    tick();
    chk("b2b_end_busy", busy, 0);

    // pause mid-word
    datai = 8'hF0; wr = 1'b1;
    tick();
    wr = 1'b0;
    bits(32'hF0, 0, 2, "pause");
    start = 1'b0;
    repeat (3) begin
      tick();
      chk("pause_hold_bit", datao, 0);
      chk("pause_hold_sync", sync, 0);
      chk("pause_hold_busy", busy, 1);
    end
    start = 1'b1;
    bits(32'hF0, 3, 7, "pause");
    tick();
    chk("pause_end_busy", busy, 0);

    // overflow
    datai = 8'h11; wr = 1'b1;
    tick();
    datai = 8'h22;
    tick();
    chk("ovf_bit0", datao, 1);
    chk("ovf_sync0", sync, 1);
    chk("ovf_ready", ready, 0);
    datai = 8'h33;
    tick();
    wr = 1'b0;
    chk("ovf_set", ovf, 1);
    chk("ovf_bit1", datao, 0);
    bits(32'h2211, 2, 15, "ovf");
    tick();
    chk("ovf_end_busy", busy, 0);
    chk("ovf_sticky", ovf, 1);

    // async reset mid-frame
    datai = 8'hA5; wr = 1'b1;
    tick();
    wr = 1'b0;
    bits(32'hA5, 0, 4, "arst");
    #1 clr = 1'b1;
    #1;
    chk("arst_datao", datao, 0);
    chk("arst_sync", sync, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", ready, 1);
    chk("arst_ovf", ovf, 0);
    #2 clr = 1'b0;
    repeat (10) begin
      tick();
      chk("arst_idle_busy", busy, 0);
      chk("arst_idle_datao", datao, 0);
    end

    // loopback through receiver
    rxq.delete();
    datai = 8'h00; wr = 1'b1;
    tick();
    datai = 8'hFF;
    tick();
    wr = 1'b0;
    n = 0;
    while (!ready && n < 20) begin
      tick();
      n++;
    end
    chk("lb_wait", n < 20, 1);
    datai = 8'h5A; wr = 1'b1;
    tick();
    wr = 1'b0;
    repeat (30) tick();
    chk("lb_count", rxq.size(), 3);
    for (int i = 0; i < 3; i++)
      chk("lb_word",
          (i < rxq.size()) ? rxq[i] : 8'hxx, ew[i]);
    chk("lb_ovf", ovf, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
